// File: rtl/key_schedule192_seq_pkg.sv
// key_schedule192_seq_pkg: shared AES-192 key-schedule types, constants and S-box helpers
package key_schedule192_seq_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  localparam int NR192 = 12;
  localparam int NWORDS192 = 52;
  localparam logic [0:7][7:0] RC = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (x^254 by square-and-multiply) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s, r;
    s = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
endpackage

// File: rtl/key_schedule192_seq_if.sv
// key_schedule192_seq_if: load/status/read-port bundle of the AES-192 key scheduler
interface key_schedule192_seq_if;
  logic start;
  logic [191:0] key_in;
  logic busy;
  logic done;
  logic [3:0] rk_idx;
  logic [127:0] rk;
  modport master(output start, key_in, rk_idx, input busy, done, rk);
  modport slave(input start, key_in, rk_idx, output busy, done, rk);
endinterface

// File: rtl/key_schedule192_seq_expand.sv
// key_schedule192_seq_expand: one combinational AES-192 key-expansion step (6 words in, 6 words out)
module key_schedule192_seq_expand
  import key_schedule192_seq_pkg::*;
(
  input  logic [191:0] keyi,
  input  word_t        rcon,
  output logic [191:0] keyf
);
  word_t t;
  logic [0:5][31:0] f;
  assign t = sub_word({keyi[23:0], keyi[31:24]}) ^ rcon;
  always_comb begin
    f[0] = keyi[191:160] ^ t;
    for (int k = 1; k < 6; k++) f[k] = keyi[191-32*k -: 32] ^ f[k-1];
  end
  assign keyf = f;
endmodule

// File: rtl/key_schedule192_seq.sv
// key_schedule192_seq: sequential AES-192 key schedule with indexed 128-bit round-key read port
module key_schedule192_seq
  import key_schedule192_seq_pkg::*;
#(
  parameter bit REG_OUT = 1'b0,
  parameter int NK_ITER = 8
) (
  input logic clk,
  input logic rst,
  key_schedule192_seq_if.slave bus
);
  state_t state, state_nx;
  word_t w [NWORDS192];
  logic [2:0] iter;
  logic [5:0] base;
  logic [191:0] keyi, keyf;
  logic [127:0] rd;
  logic last, load;
  assign last = iter == 3'(NK_ITER - 1);
  assign load = bus.start && state != EXPAND;
  assign base = 6'(iter) * 6'd6;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = load ? EXPAND : (state == EXPAND && last) ? READY : state;
  end
  always_comb begin
    bus.busy = state == EXPAND;
    bus.done = state == READY;
  end
  always_comb begin
    keyi = '0;
    for (int k = 0; k < 6; k++) keyi[191-32*k -: 32] = w[base + 6'(k)];
  end
  key_schedule192_seq_expand u_step (.keyi(keyi), .rcon({RC[iter], 24'h0}), .keyf(keyf));
  // Each output word has a fixed slot per iteration; the last step naturally stops at w[51]
  always_ff @(posedge clk) begin
    if (rst) begin
      iter <= '0;
      for (int j = 0; j < NWORDS192; j++) w[j] <= '0;
    end else if (load) begin
      iter <= '0;
      for (int k = 0; k < 6; k++) w[k] <= bus.key_in[191-32*k -: 32];
    end else if (state == EXPAND) begin
      iter <= iter + 3'd1;
      for (int j = 6; j < NWORDS192; j++)
        if (3'(j / 6 - 1) == iter) w[j] <= keyf[191-32*(j%6) -: 32];
    end
  end
  assign rd = bus.rk_idx > 4'(NR192) ? '0 :
              {w[{bus.rk_idx, 2'd0}], w[{bus.rk_idx, 2'd1}], w[{bus.rk_idx, 2'd2}], w[{bus.rk_idx, 2'd3}]};
  generate
    if (REG_OUT) begin : g_reg
      logic [127:0] rk_q;
      always_ff @(posedge clk)
        if (rst) rk_q <= '0;
        else rk_q <= rd;
      assign bus.rk = rk_q;
    end else begin : g_comb
      assign bus.rk = rd;
    end
  endgenerate
endmodule

// File: doc/key_schedule192_seq.md
Name: key_schedule192_seq

Overview:
- Sequential AES-192 key-schedule generator. Feeds the round-key input of the AES-192 cipher round datapath.
- Loads a 192-bit cipher key, then applies the one-step 192-bit key-expansion function once per cycle for 8 cycles, producing all 52 schedule words.
- Stores the schedule and serves the 13 128-bit round keys through an indexed read port.

Parameters:
REG_OUT, 0, 0 = round-key read is combinational from rk_idx; 1 = rk registered, 1-cycle read latency
NK_ITER, 8, number of expansion steps; fixed for AES-192, not to be overridden

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle load strobe; sampled when state is IDLE or READY
key_in  in  192  cipher key; key_in[191:160] = w0 ... key_in[31:0] = w5
busy  out  1  high while the schedule is loading or expanding
done  out  1  high while a complete, valid schedule is held
rk_idx  in  4  round-key index, 0..12
rk  out  128  round key rk_idx; rk[127:96] = w[4*rk_idx] ... rk[31:0] = w[4*rk_idx+3]

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high on rst.
  - Reset: state=IDLE, busy=0, done=0, iteration counter=0, all 52 words=0, registered rk=0.
  - rst has priority over start.
- Storage: 52 x 32-bit word array w[0..51]. Word order is big-endian by column; w0 is the most significant key word.
- FSM states: IDLE, EXPAND, READY.
  - IDLE, start=1: latch key_in into w[0..5]; iter=0; go to EXPAND; busy=1 from the next cycle.
  - EXPAND: each cycle, the expansion step input is w[6*iter .. 6*iter+5], packed as 192 bits with w[6*iter] in the MSBs.
    - rcon = {RC[iter], 24'h0}, with RC = 01,02,04,08,10,20,40,80.
    - Step output is written to w[6*(iter+1) .. 6*(iter+1)+5].
    - On iter=7, only the first 4 output words are written (w[48..51]); the remaining 2 are discarded.
    - iter increments each cycle.
    - After the iter=7 write: go to READY, busy=0, done=1.
  - READY, start=1: behaves as in IDLE (reload, done drops to 0 the next cycle). Without start, hold indefinitely.
  - start while in EXPAND is ignored; it is not queued.
- Latency: start sampled at edge N; done=1 after edge N+8; busy=1 for cycles N+1..N+8.
- Rcon: held as an 8-entry constant table indexed by iter. No multiplier.
- Read port:
  - REG_OUT=0: rk = {w[4i], w[4i+1], w[4i+2], w[4i+3]} for i=rk_idx, combinational.
  - REG_OUT=1: the same value is registered, appearing 1 cycle after rk_idx.
  - rk_idx 13..15: rk=128'h0.
  - rk reflects current array contents in every state. It is guaranteed correct only while done=1.
- Reset mid-expansion aborts. No partial done is ever asserted.
- The step is purely combinational from the word array, so the critical path is one expansion step (4 S-boxes plus an XOR chain).

Decomposition:
- Shared package aes_pkg holds:
  - the RC table constant (8 x 8-bit);
  - the word type (32-bit);
  - NR192=12 and NWORDS192=52 constants;
  - the FSM state typedef.
- Natural sub-module: the existing combinational one-step expansion module Key_Expansion192 (KeyI, rcon, KeyF), instantiated once and reused every cycle.
- The S-boxes stay inside that sub-module.

Test Plan:
1. Reset, then key_in=000102030405060708090a0b0c0d0e0f1011121314151617, pulse start -> busy high 8 cycles, done rises 8 cycles after start; rk_idx=0 gives 000102030405060708090a0b0c0d0e0f.
2. Same key, done=1 -> rk_idx=1 gives 10111213141516175846f2f95c43f4fe; rk_idx=12 gives a4970a331a78dc09c418c271e3a41d5d.
3. Key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_idx=1 gives 62f8ead2522c6b7bfe0c91f72402f5a5; rk_idx=12 matches a software reference model.
4. start pulsed at expansion cycle 3 with a different key_in -> ignored; final schedule matches the first key; done timing unchanged.
5. rst asserted at expansion cycle 5 -> next cycle busy=0, done=0, rk_idx=0 gives all zero; a fresh start completes normally.
6. done=1, then start with a new key -> done falls the next cycle and re-rises 8 cycles later with the new schedule. rk_idx=13 gives zero. With REG_OUT=1, rk updates one cycle after rk_idx changes.
